// File: rtl/mmio_io_hub.sv
// -----------------------------------------------------------------------------
// mmio_io_hub
//
// Purpose:
//   Memory-mapped I/O hub for a small CPU. It exposes N_IN read-only input
//   channels, N_OUT write-only output registers (each with a one-cycle write
//   strobe), and an interrupt block with edge-detected pending bits, a mask
//   register and a registered interrupt request.
//
// Address map (exact 32-bit compare, everything else unmapped):
//   BASE_ADDR + 0x000 + 0x20*k : input channel k   (read)
//   BASE_ADDR + 0x200 + 0x20*k : output register k (write; read when enabled)
//   BASE_ADDR + 0x400          : PENDING (read, write-1-to-clear)
//   BASE_ADDR + 0x404          : MASK    (read/write)
//
// Configuration macro:
//   MMIO_READBACK_EN : when defined, reads of output register k return
//                      OUT_DATA[k]; when undefined they return 0 and no
//                      readback multiplexer is built.
//
// Ports:
//   CLK        in   1          single clock, rising edge
//   RST_N      in   1          synchronous active-low reset
//   IOBUS_ADDR in   32         CPU MMIO address
//   IOBUS_OUT  in   32         CPU write data
//   IOBUS_WR   in   1          CPU write strobe
//   IOBUS_IN   out  32         combinational read data to the CPU
//   IN_DATA    in   32*N_IN    input channel k at bits [32k+31:32k]
//   OUT_DATA   out  32*N_OUT   output register k at bits [32k+31:32k]
//   OUT_WE     out  N_OUT      one-cycle write strobe per output register
//   IRQ_IN     in   N_IRQ      level interrupt sources, synchronous to CLK
//   INTR       out  1          registered interrupt request
// -----------------------------------------------------------------------------
module mmio_io_hub #(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
   parameter int          N_IN      = 4,
   parameter int          N_OUT     = 4,
   parameter int          N_IRQ     = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [31:0]          IOBUS_ADDR,
   input  logic [31:0]          IOBUS_OUT,
   input  logic                 IOBUS_WR,
   output logic [31:0]          IOBUS_IN,
   input  logic [32*N_IN-1:0]   IN_DATA,
   output logic [32*N_OUT-1:0]  OUT_DATA,
   output logic [N_OUT-1:0]     OUT_WE,
   input  logic [N_IRQ-1:0]     IRQ_IN,
   output logic                 INTR
);

   localparam logic [31:0] OUT_BASE  = BASE_ADDR + 32'h0000_0200;
   localparam logic [31:0] PEND_ADDR = BASE_ADDR + 32'h0000_0400;
   localparam logic [31:0] MASK_ADDR = BASE_ADDR + 32'h0000_0404;

   logic [32*N_OUT-1:0] r_out_data;
   logic [N_OUT-1:0]    r_out_we;
   logic [N_IRQ-1:0]    r_irq_q;
   logic [N_IRQ-1:0]    r_pending;
   logic [N_IRQ-1:0]    r_mask;
   logic                r_intr;

   logic [N_OUT-1:0]    w_out_wr;
   logic                w_pend_sel;
   logic                w_mask_sel;
   logic [N_IRQ-1:0]    w_rise;
   logic [N_IRQ-1:0]    w_clr;
   logic [N_IRQ-1:0]    w_pend_nxt;
   logic [31:0]         w_rdata;

   // Write decode
   always_comb begin
      w_out_wr = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (IOBUS_WR && (IOBUS_ADDR == OUT_BASE + 32'(k) * 32'h20)) begin
            w_out_wr[k] = 1'b1;
         end
      end
   end

   assign w_pend_sel = (IOBUS_ADDR == PEND_ADDR);
   assign w_mask_sel = (IOBUS_ADDR == MASK_ADDR);

   // Pending update: set on a fresh rising level, W1C from the CPU.
   // Applying the set after the clear makes a coincident set win.
   assign w_rise     = IRQ_IN & ~r_irq_q;
   assign w_clr      = (IOBUS_WR && w_pend_sel) ? IOBUS_OUT[N_IRQ-1:0] : '0;
   assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;

   always_ff @(posedge CLK) begin
      // The edge detector keeps sampling IRQ_IN while in reset, so a level
      // already high when reset releases is not mistaken for a new edge.
      r_irq_q <= IRQ_IN;
      if (!RST_N) begin
         r_out_data <= '0;
         r_out_we   <= '0;
         r_pending  <= '0;
         r_mask     <= '0;
         r_intr     <= 1'b0;
      end else begin
         r_out_we <= w_out_wr;
         for (int k = 0; k < N_OUT; k++) begin
            if (w_out_wr[k]) begin
               r_out_data[32*k +: 32] <= IOBUS_OUT;
            end
         end
         r_pending <= w_pend_nxt;
         if (IOBUS_WR && w_mask_sel) begin
            r_mask <= IOBUS_OUT[N_IRQ-1:0];
         end
         // Uses the registered pending/mask, giving two edges from IRQ_IN
         // rising to INTR high.
         r_intr <= |(r_pending & r_mask);
      end
   end

   // Combinational read mux, independent of reset
   always_comb begin
      w_rdata = 32'h0;
      for (int k = 0; k < N_IN; k++) begin
         if (IOBUS_ADDR == BASE_ADDR + 32'(k) * 32'h20) begin
            w_rdata = IN_DATA[32*k +: 32];
         end
      end
`ifdef MMIO_READBACK_EN
      for (int k = 0; k < N_OUT; k++) begin
         if (IOBUS_ADDR == OUT_BASE + 32'(k) * 32'h20) begin
            w_rdata = r_out_data[32*k +: 32];
         end
      end
`endif
      if (w_pend_sel) begin
         w_rdata = 32'(r_pending);
      end
      if (w_mask_sel) begin
         w_rdata = 32'(r_mask);
      end
   end

   assign IOBUS_IN = w_rdata;
   assign OUT_DATA = r_out_data;
   assign OUT_WE   = r_out_we;
   assign INTR     = r_intr;

endmodule

// File: tb/tb_mmio_io_hub.sv
module tb_mmio_io_hub;

  localparam logic [31:0] A_IN0  = 32'h1100_0000;
  localparam logic [31:0] A_OUT0 = 32'h1100_0200;
  localparam logic [31:0] A_PEND = 32'h1100_0400;
  localparam logic [31:0] A_MASK = 32'h1100_0404;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [31:0]  IOBUS_ADDR = 32'h0;
  logic [31:0]  IOBUS_OUT = 32'h0;
  logic         IOBUS_WR = 1'b0;
  logic [31:0]  IOBUS_IN;
  logic [127:0] IN_DATA;
  logic [127:0] OUT_DATA;
  logic [3:0]   OUT_WE;
  logic [1:0]   IRQ_IN = 2'b00;
  logic         INTR;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_out[4];
  int unsigned rk;
  logic [31:0] rdat;
  logic [3:0]  we_e;

  mmio_io_hub dut (
    .CLK(CLK), .RST_N(RST_N),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
    .OUT_WE(OUT_WE), .IRQ_IN(IRQ_IN), .INTR(INTR)
  );

  // clock
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
  endtask

  // scoreboard
  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    IOBUS_ADDR = a;
    #1;
    chk(tag, IOBUS_IN);
  endtask

  task automatic chk_outs(input string tag);
    for (int k = 0; k < 4; k++) begin
      push_exp(m_out[k]);
      chk(tag, OUT_DATA[32*k +: 32]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m_out[k] = 32'h0;
    IN_DATA = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

    // reset, with a coincident write that must be discarded
    RST_N = 1'b0;
    IOBUS_ADDR = A_OUT0; IOBUS_OUT = 32'hDEAD_0000; IOBUS_WR = 1'b1;
    tick(); tick();
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0;
    chk_outs("reset_out_data");
    push_exp(32'h0); chk("reset_out_we", 32'(OUT_WE));
    push_exp(32'h0); chk("reset_intr", 32'(INTR));
    push_exp(32'hCAFE_0001); rd(A_IN0 + 32'h20, "read_during_reset");
    RST_N = 1'b1;
    tick();
    push_exp(32'h0); rd(A_PEND, "reset_pending");
    push_exp(32'h0); rd(A_MASK, "reset_mask");

    // read mux
    tick();
    push_exp(32'hCAFE_0002); rd(32'h1100_0040, "read_in2");
    push_exp(32'h0);         rd(32'h1100_0044, "read_in2_subword");
    push_exp(32'hCAFE_0000); rd(32'h1100_0000, "read_in0");
    push_exp(32'hCAFE_0003); rd(32'h1100_0060, "read_in3");
    push_exp(32'h0);         rd(32'h1100_0080, "read_past_inputs");
    tick();
    push_exp(32'h0);         rd(32'h1200_0040, "read_other_window");

    // output strobe
    tick();
    IOBUS_ADDR = 32'h1100_0220; IOBUS_OUT = 32'h0000_BEEF; IOBUS_WR = 1'b1;
    push_exp(32'h0); chk("we_before_edge", 32'(OUT_WE));
    tick();
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0;
    m_out[1] = 32'h0000_BEEF;
    push_exp(32'h2); chk("we_out1", 32'(OUT_WE));
    chk_outs("out1_write");
    tick();
    push_exp(32'h0); chk("we_out1_drop", 32'(OUT_WE));

    // back-to-back writes to output 3
    IOBUS_ADDR = 32'h1100_0260; IOBUS_OUT = 32'h1; IOBUS_WR = 1'b1;
    tick();
    m_out[3] = 32'h1;
    push_exp(32'h8); chk("b2b_we_1", 32'(OUT_WE));
    push_exp(m_out[3]); chk("b2b_data_1", OUT_DATA[127:96]);
    IOBUS_OUT = 32'h2;
    tick();
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0;
    m_out[3] = 32'h2;
    push_exp(32'h8); chk("b2b_we_2", 32'(OUT_WE));
    push_exp(m_out[3]); chk("b2b_data_2", OUT_DATA[127:96]);
    tick();
    push_exp(32'h0); chk("b2b_we_drop", 32'(OUT_WE));

    // writes with no effect
    do_write(A_IN0, 32'hFFFF_FFFF);
    push_exp(32'h0); chk("wr_input_we", 32'(OUT_WE));
    chk_outs("wr_input_out");
    do_write(A_OUT0 + 32'h4, 32'hAAAA_AAAA);
    push_exp(32'h0); chk("wr_subword_we", 32'(OUT_WE));
    chk_outs("wr_subword_out");
    do_write(A_OUT0 + 32'h80, 32'h5555_5555);
    push_exp(32'h0); chk("wr_past_outputs_we", 32'(OUT_WE));
    chk_outs("wr_past_outputs_out");

    // random output writes
    for (int i = 0; i < 8; i++) begin
      rk = $urandom_range(0, 3);
      rdat = $urandom;
      m_out[rk] = rdat;
      we_e = 4'h0;
      we_e[rk] = 1'b1;
      push_exp(32'(we_e));
      do_write(A_OUT0 + rk * 32'h20, rdat);
      chk("rand_we", 32'(OUT_WE));
      chk_outs("rand_out");
    end
    tick();

    // interrupt path
    do_write(A_MASK, 32'hFFFF_FFFD);
    push_exp(32'h1); rd(A_MASK, "mask_low_bits");
    IOBUS_ADDR = 32'h0;
    IRQ_IN = 2'b01;
    tick();
    push_exp(32'h1); rd(A_PEND, "pending_after_1_edge");
    push_exp(32'h0); chk("intr_after_1_edge", 32'(INTR));
    tick();
    push_exp(32'h1); chk("intr_after_2_edges", 32'(INTR));
    do_write(A_PEND, 32'h1);
    push_exp(32'h0); rd(A_PEND, "pending_cleared");
    push_exp(32'h1); chk("intr_1_edge_after_clear", 32'(INTR));
    tick();
    push_exp(32'h0); chk("intr_2_edges_after_clear", 32'(INTR));
    tick();
    push_exp(32'h0); rd(A_PEND, "no_retrigger_held");
    push_exp(32'h0); chk("intr_no_retrigger", 32'(INTR));

    // set/clear collision on pending[1]
    IRQ_IN = 2'b11;
    do_write(A_PEND, 32'h2);
    push_exp(32'h2); rd(A_PEND, "collision_set_wins");
    push_exp(32'h0); chk("collision_intr_masked", 32'(INTR));

    // masking a pending source
    do_write(A_MASK, 32'h3);
    push_exp(32'h0); chk("unmask_intr_1", 32'(INTR));
    tick();
    push_exp(32'h1); chk("unmask_intr_2", 32'(INTR));
    do_write(A_MASK, 32'h0);
    push_exp(32'h1); chk("mask_intr_1", 32'(INTR));
    tick();
    push_exp(32'h0); chk("mask_intr_2", 32'(INTR));
    push_exp(32'h2); rd(A_PEND, "mask_pending_kept");

    // reset mid-operation
    do_write(A_OUT0, 32'h0000_1234);
    m_out[0] = 32'h0000_1234;
    do_write(A_MASK, 32'h3);
    tick();
    push_exp(32'h1); chk("pre_reset_intr", 32'(INTR));
    push_exp(32'h0000_1234); chk("pre_reset_out0", OUT_DATA[31:0]);
    RST_N = 1'b0;
    IOBUS_ADDR = A_OUT0; IOBUS_OUT = 32'hDEAD_BEEF; IOBUS_WR = 1'b1;
    tick();
    RST_N = 1'b1;
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0;
    for (int k = 0; k < 4; k++) m_out[k] = 32'h0;
    chk_outs("midrst_out_data");
    push_exp(32'h0); chk("midrst_we", 32'(OUT_WE));
    push_exp(32'h0); chk("midrst_intr", 32'(INTR));
    push_exp(32'h0); rd(A_PEND, "midrst_pending");
    push_exp(32'h0); rd(A_MASK, "midrst_mask");
    do_write(A_MASK, 32'h3);
    tick();
    push_exp(32'h0); rd(A_PEND, "post_rst_held_no_pending");
    push_exp(32'h0); chk("post_rst_held_no_intr", 32'(INTR));

    // readback
    do_write(A_OUT0, 32'h55);
    m_out[0] = 32'h55;
    push_exp(m_out[0]); chk("readback_out0_data", OUT_DATA[31:0]);
`ifdef MMIO_READBACK_EN
    push_exp(32'h55);
`else
    push_exp(32'h0);
`endif
    rd(A_OUT0, "readback_read");

    tick();
    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0 entries left", exp_q.size());
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
